// File: rtl/shift_register_param.sv
// Parametrised serial shifter: parallel load via valid/ready, WIDTH bits per frame,
// MSB- or LSB-first, rotate or shift (deserialise) mode, captured word at frame end.
module shift_register_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] I,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             dir,
  input  logic             rotate,
  input  logic             serial_in,
  input  logic             shift_en,
  output logic             shift_out,
  output logic             shift_valid,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               rot_q, rot_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic               done_q, done_d;

  logic               active;
  logic               out_bit;
  logic               fill;
  logic               consume;
  logic               is_last;
  logic               frame_end;
  logic               ready;
  logic               accept;
  logic [WIDTH-1:0]   shifted;

  // Datapath decode: current bit, fill bit, handshake and the post-shift word.
  always_comb begin
    active    = (state_q == StShift);
    out_bit   = dir_q ? sr_q[0] : sr_q[WIDTH-1];
    fill      = rot_q ? out_bit : serial_in;
    consume   = active & shift_en;
    is_last   = active & (cnt_q == CNT_W'(WIDTH - 1));
    frame_end = is_last & shift_en;
    // A load may land on the last-consume edge, giving back-to-back frames.
    ready     = ~active | frame_end;
    accept    = load_valid & ready;
    shifted   = dir_q ? {fill, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], fill};
  end

  // Next-state: consume advances the frame; a load accept overrides it.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    rx_d    = rx_q;
    done_d  = frame_end;
    if (consume) begin
      sr_d  = shifted;
      cnt_d = cnt_q + CNT_W'(1);
      if (frame_end) begin
        state_d = StIdle;
        rx_d    = shifted;
      end
    end
    if (accept) begin
      state_d = StShift;
      sr_d    = I;
      dir_d   = dir;
      rot_d   = rotate;
      cnt_d   = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      rx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
    end
  end

  // Outputs; shift_out is forced low outside a frame.
  always_comb begin
    load_ready  = ready;
    shift_out   = active & out_bit;
    shift_valid = active;
    busy        = active;
    last        = is_last;
    done        = done_q;
    rx_data     = rx_q;
  end

endmodule

// File: tb/tb_shift_register_param.sv
// Scoreboard bench for shift_register_param at WIDTH=16 and WIDTH=8.
module tb_shift_register_param;

  typedef struct packed {
    logic b;
    logic l;
  } exp_bit_t;

  logic        clock;
  logic        reset_n;
  logic [15:0] I;
  logic        load_valid;
  logic        dir;
  logic        rotate;
  logic        serial_in;
  logic        shift_en;

  logic        ready16, so16, sv16, last16, busy16, done16;
  logic [15:0] rx16;
  logic        ready8, so8, sv8, last8, busy8, done8;
  logic [7:0]  rx8;

  int          n_checks = 0;
  int          n_fail   = 0;

  exp_bit_t    bit_q[$];
  logic [63:0] rx_q[$];
  logic        exp_done   = 1'b0;
  logic        accepted   = 1'b0;
  logic        sel        = 1'b0;  // 0: check WIDTH=16 instance, 1: WIDTH=8
  int          mk         = 0;     // bits consumed in the modelled frame
  logic [15:0] pend_sword = '0;    // serial word to feed for the next loaded frame
  logic [15:0] act_sword  = '0;
  logic        act_sdir   = 1'b0;

  shift_register_param #(.WIDTH(16)) u_dut16 (
    .clock       (clock),
    .reset_n     (reset_n),
    .I           (I),
    .load_valid  (load_valid),
    .load_ready  (ready16),
    .dir         (dir),
    .rotate      (rotate),
    .serial_in   (serial_in),
    .shift_en    (shift_en),
    .shift_out   (so16),
    .shift_valid (sv16),
    .last        (last16),
    .busy        (busy16),
    .done        (done16),
    .rx_data     (rx16)
  );

  shift_register_param #(.WIDTH(8)) u_dut8 (
    .clock       (clock),
    .reset_n     (reset_n),
    .I           (I[7:0]),
    .load_valid  (load_valid),
    .load_ready  (ready8),
    .dir         (dir),
    .rotate      (rotate),
    .serial_in   (serial_in),
    .shift_en    (shift_en),
    .shift_out   (so8),
    .shift_valid (sv8),
    .last        (last8),
    .busy        (busy8),
    .done        (done8),
    .rx_data     (rx8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare the selected DUT against the scoreboard; called at the falling edge.
  task automatic monitor();
    int          w;
    logic        so, sv, lst, bsy, dn, rdy, exp_rdy, nxt_done;
    logic [63:0] rx, mask;
    exp_bit_t    fb;
    w        = sel ? 8 : 16;
    so       = sel ? so8 : so16;
    sv       = sel ? sv8 : sv16;
    lst      = sel ? last8 : last16;
    bsy      = sel ? busy8 : busy16;
    dn       = sel ? done8 : done16;
    rdy      = sel ? ready8 : ready16;
    rx       = sel ? {56'd0, rx8} : {48'd0, rx16};
    mask     = (64'd1 << w) - 64'd1;
    accepted = 1'b0;
    nxt_done = 1'b0;

    exp_rdy = (bit_q.size() == 0) || (bit_q[0].l && shift_en);
    check_eq("load_ready", rdy, exp_rdy);
    check_eq("shift_valid", sv, bit_q.size() != 0);
    check_eq("busy", bsy, bit_q.size() != 0);
    check_eq("done", dn, exp_done);
    if (exp_done) begin
      if (rx_q.size() == 0) check_eq("rx_queue", 64'(rx_q.size()), 64'd1);
      else check_eq("rx_data", rx, rx_q.pop_front());
    end

    if (bit_q.size() != 0) begin
      fb = bit_q[0];
      check_eq("shift_out", so, fb.b);
      check_eq("last", lst, fb.l);
      if (shift_en) begin
        void'(bit_q.pop_front());
        mk++;
        if (fb.l) nxt_done = 1'b1;
      end
    end else begin
      check_eq("idle_shift_out", so, 1'b0);
      check_eq("idle_last", lst, 1'b0);
    end

    if (load_valid && exp_rdy) begin
      for (int k = 0; k < w; k++) begin
        bit_q.push_back('{b: (dir ? I[k] : I[w-1-k]), l: (k == w - 1)});
      end
      rx_q.push_back(rotate ? (64'(I) & mask) : (64'(pend_sword) & mask));
      act_sword = pend_sword;
      act_sdir  = dir;
      mk        = 0;
      accepted  = 1'b1;
    end
    exp_done = nxt_done;
  endtask

  // One clock: drive serial_in for the modelled frame, check, step past the edge.
  task automatic cycle();
    int w;
    w = sel ? 8 : 16;
    if (bit_q.size() != 0 && mk < w) serial_in = act_sdir ? act_sword[mk] : act_sword[w-1-mk];
    else serial_in = 1'b0;
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_valid16", {sv16, busy16, last16, so16, done16}, 5'b0);
    check_eq("rst_ready16", ready16, 1'b1);
    check_eq("rst_rx16", rx16, 16'h0000);
    check_eq("rst_valid8", {sv8, busy8, last8, so8, done8}, 5'b0);
    check_eq("rst_ready8", ready8, 1'b1);
    check_eq("rst_rx8", rx8, 8'h00);
    bit_q.delete();
    rx_q.delete();
    exp_done = 1'b0;
    mk       = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic got;
    reset_n    = 1'b1;
    I          = '0;
    load_valid = 1'b0;
    dir        = 1'b0;
    rotate     = 1'b0;
    serial_in  = 1'b0;
    shift_en   = 1'b0;
    #2;
    do_reset();
    repeat (2) cycle();

    // Rotate, MSB-first, continuous shifting.
    I = 16'hA5C3; dir = 1'b0; rotate = 1'b1; shift_en = 1'b1; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    repeat (19) cycle();

    // Shift mode, LSB-first, deserialising 0x1234.
    I = 16'h00FF; dir = 1'b1; rotate = 1'b0; pend_sword = 16'h1234; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    repeat (19) cycle();

    // Rotate with shift_en alternating: each bit held for two cycles.
    I = 16'hA5C3; dir = 1'b0; rotate = 1'b1; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 36; i++) begin
      shift_en = i[0];
      cycle();
    end
    shift_en = 1'b1;
    repeat (2) cycle();

    // Back-to-back frames with load_valid held, then a mid-frame pulse.
    I = 16'hA5C3; dir = 1'b0; rotate = 1'b1; load_valid = 1'b1;
    cycle();
    I = 16'h0001; dir = 1'b1; rotate = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = accepted;
    end
    check_eq("b2b_accept", got, 1'b1);
    load_valid = 1'b0;
    repeat (5) cycle();
    I = 16'hFFFF; dir = 1'b0; rotate = 1'b0; load_valid = 1'b1;
    cycle();
    check_eq("midframe_ignored", accepted, 1'b0);
    load_valid = 1'b0;
    repeat (14) cycle();

    // WIDTH=8: shift mode with serial_in=1, aborted by reset, then completed.
    sel = 1'b1;
    repeat (2) cycle();
    I = 16'h003C; dir = 1'b0; rotate = 1'b0; pend_sword = 16'h00FF; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    repeat (5) cycle();
    do_reset();
    repeat (3) cycle();
    I = 16'h003C; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    repeat (11) cycle();

    check_eq("bits_drained", 64'(bit_q.size()), 64'd0);
    check_eq("rx_drained", 64'(rx_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
- Parametrised serial shifter, successor to the fixed 16-bit rotating shift register.
- Parallel word in through a valid/ready load handshake. Each frame shifts exactly WIDTH bits, MSB-first or LSB-first.
- Two modes per frame: rotate (word recirculates) or shift (serial_in fills vacated bits, so the block also works as a deserialiser).
- Sits between parallel datapath registers and a serial link or bit-serial unit.

Parameters:
WIDTH, 16, register/frame width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
I  input  WIDTH  parallel load word
load_valid  input  1  load request
load_ready  output  1  load accepted when load_valid & load_ready at rising edge
dir  input  1  0 = MSB-first, shifts toward MSB; 1 = LSB-first, shifts toward LSB; sampled at load only
rotate  input  1  1 = rotate mode, 0 = shift mode; sampled at load only
serial_in  input  1  fill bit in shift mode
shift_en  input  1  consume current bit / advance; 0 = stall
shift_out  output  1  current serial bit
shift_valid  output  1  shift_out is valid (frame active)
last  output  1  shift_out is bit WIDTH-1 of the frame
busy  output  1  frame in progress (equal to shift_valid)
done  output  1  one-cycle pulse, registered, in the cycle after the last bit is consumed
rx_data  output  WIDTH  register contents captured at frame end

Behaviour:
- Reset (async, reset_n=0): state IDLE; shift register, counter, mode flops, rx_data, done all 0. Outputs shift_out=0, shift_valid=0, last=0, busy=0, load_ready=1. Takes effect immediately, including mid-frame; the aborted frame never produces done.
- States: IDLE and SHIFT.
- IDLE -> SHIFT on load accept. At that edge: reg<=I, dir and rotate latched, count<=0.
- Output bit: dir=0 -> shift_out=reg[WIDTH-1]; dir=1 -> shift_out=reg[0]. Forced to 0 in IDLE.
- Fill bit: rotate=1 -> the outgoing bit; rotate=0 -> serial_in.
- Consume: in SHIFT with shift_en=1, at the edge:
  - dir=0: reg<={reg[WIDTH-2:0],fill}
  - dir=1: reg<={fill,reg[WIDTH-1:1]}
  - count<=count+1
- Stall: shift_en=0 in SHIFT holds reg, count and shift_out. shift_en is ignored in IDLE.
- last = SHIFT & (count==WIDTH-1).
- Frame end, on the edge where last & shift_en:
  - rx_data<=post-shift reg value; done<=1 for the next cycle only.
  - Rotate mode: rx_data equals the loaded word.
  - Shift mode: rx_data equals the WIDTH serial_in bits. dir=0: first received bit lands in MSB. dir=1: first received bit lands in LSB.
  - Next state is SHIFT if a load is accepted at the same edge, else IDLE.
- load_ready = IDLE | (last & shift_en). This allows back-to-back frames with no bubble; a simultaneous frame end and load takes the new word, new dir/rotate, and count<=0.
- load_valid during a frame, outside the last-consume cycle, is not accepted and has no effect. I, dir and rotate may change freely mid-frame.
- Latency: first bit on shift_out in the cycle after load accept. A frame with shift_en held at 1 lasts exactly WIDTH cycles; done asserts at cycle WIDTH+1 after accept.
- No X on any output after reset.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> all outputs 0 and load_ready=1 without a clock edge; rx_data=0x0000.
- WIDTH=16, load 0xA5C3, dir=0, rotate=1, shift_en=1 -> shift_out 1010010111000011 over 16 cycles; last only on the 16th; done one cycle later; rx_data=0xA5C3; back in IDLE.
- Load 0x00FF, dir=1, rotate=0, serial_in driven LSB-first with 0x1234 -> shift_out eight 1s then eight 0s; rx_data=0x1234.
- Same as the rotate case with shift_en alternating 1/0 -> each bit held for 2 cycles; frame spans 32 cycles; shift_out stable while stalled; single done pulse.
- Back-to-back: first 0xA5C3, then 0x0001 (dir=1, rotate=1) with load_valid held -> second load accepted at the first frame's last edge; shift_valid high for 32 continuous cycles; done after bit 16 with rx_data=0xA5C3; done again after bit 32 with rx_data=0x0001. Also: load_valid pulsed mid-frame is ignored.
- WIDTH=8, 8'h3C, dir=0, rotate=0, serial_in=1 constant; reset_n pulsed low after 5 consumed bits -> immediate IDLE, no done, rx_data=0. Reload and complete -> rx_data=8'hFF.
